// File: rtl/common.sv
// Shared memory-pipeline types: ROB id width, store-queue geometry, entry layout
// and the wrap-bit age comparison also used by the issue queues.
package common;

  localparam int ROB_WIDTH = 4;
  localparam int SQ_NUM    = 8;
  localparam int SQ_WIDTH  = 3;
  localparam int SQ_SKID   = 2;

  typedef logic [ROB_WIDTH:0] robid_t;

  typedef struct packed {
    logic        valid;
    logic        committed;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    robid_t      robid;
  } sq_entry_t;

  // True when a is younger than b; the MSB of a robid is the wrap bit.
  function automatic logic rob_younger(input robid_t a, input robid_t b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH])
      return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
    else
      return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
  endfunction

  // Byte-enable lanes of an access; size 2'b11 is unused and treated as word.
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << ofs;
  endfunction

endpackage

// File: rtl/sq_fwd_lookup.sv
// Store-to-load forwarding search: youngest older overlapping store wins, then
// a full-coverage check decides between forwarding and stalling the load.
module sq_fwd_lookup
  import common::*;
#(
  parameter int SQ_NUM   = common::SQ_NUM,
  parameter int SQ_WIDTH = common::SQ_WIDTH
) (
  input  sq_entry_t [SQ_NUM-1:0] entries,
  input  logic [SQ_WIDTH-1:0]    head,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [1:0]             ld_size,
  input  logic [ROB_WIDTH:0]     ld_robid,
  output logic                   fwd_hit,
  output logic [31:0]            fwd_data,
  output logic                   fwd_stall
);

  logic [3:0]          ld_mask;
  logic [SQ_NUM-1:0]   match;
  logic [SQ_NUM-1:0]   unused_committed;
  logic                found;
  logic [SQ_WIDTH-1:0] scan_idx;
  logic [SQ_WIDTH-1:0] sel_idx;

  assign ld_mask = size_mask(ld_size, ld_addr[1:0]);

  generate
    for (genvar gi = 0; gi < SQ_NUM; gi++) begin : g_match
      assign match[gi] = entries[gi].valid
                       && (entries[gi].addr == ld_addr[31:2])
                       && (|(entries[gi].mask & ld_mask))
                       && rob_younger(ld_robid, entries[gi].robid);
      assign unused_committed[gi] = entries[gi].committed;
    end
  endgenerate

  // Walk oldest to youngest so the last match seen is the youngest candidate.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < SQ_NUM; i++) begin
      scan_idx = head + SQ_WIDTH'(i);
      if (match[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end

    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid && found) begin
      if ((entries[sel_idx].mask & ld_mask) == ld_mask) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[sel_idx].data;
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_store_queue.sv
// In-order store queue: buffers executed stores, releases them to the data cache
// after ROB commit, discards speculative entries on flush, forwards to loads.
module mem_store_queue
  import common::*;
#(
  parameter int SQ_NUM   = common::SQ_NUM,
  parameter int SQ_WIDTH = common::SQ_WIDTH,
  parameter int SQ_SKID  = common::SQ_SKID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_valid,
  input  logic [31:0]          st_addr,
  input  logic [31:0]          st_data,
  input  logic [1:0]           st_size,
  input  logic [ROB_WIDTH:0]   st_robid,
  output logic                 sq_full,
  output logic                 sq_empty,
  input  logic                 commit0_valid,
  input  logic [ROB_WIDTH:0]   commit0_robid,
  input  logic                 commit1_valid,
  input  logic [ROB_WIDTH:0]   commit1_robid,
  input  logic                 flush_valid,
  input  logic [ROB_WIDTH:0]   flush_robid,
  input  logic                 ld_valid,
  input  logic [31:0]          ld_addr,
  input  logic [1:0]           ld_size,
  input  logic [ROB_WIDTH:0]   ld_robid,
  output logic                 fwd_hit,
  output logic [31:0]          fwd_data,
  output logic                 fwd_stall,
  output logic                 dc_req_valid,
  output logic [31:0]          dc_req_addr,
  output logic [31:0]          dc_req_data,
  output logic [3:0]           dc_req_mask,
  input  logic                 dc_req_ready
);

  localparam logic [SQ_WIDTH:0] FULL_LEVEL = (SQ_WIDTH+1)'(SQ_NUM - SQ_SKID);

  sq_entry_t [SQ_NUM-1:0] entries_reg, entries_next;
  logic [SQ_WIDTH-1:0]    head_reg, head_next;
  logic [SQ_WIDTH-1:0]    tail_reg, tail_next;
  logic [SQ_WIDTH:0]      count_reg, count_next;
  logic [SQ_NUM-1:0]      committed_c;
  logic [SQ_NUM-1:0]      flushed;
  logic [SQ_WIDTH:0]      flush_cnt;
  logic                   alloc;
  logic                   drain;

  assign alloc = st_valid & ~flush_valid;
  assign drain = dc_req_valid & dc_req_ready;

  // Commit is resolved before flush so a store retiring this cycle survives it.
  generate
    for (genvar gi = 0; gi < SQ_NUM; gi++) begin : g_entry
      assign committed_c[gi] = entries_reg[gi].committed
                             | (entries_reg[gi].valid
                                & ((commit0_valid & (entries_reg[gi].robid == commit0_robid))
                                 | (commit1_valid & (entries_reg[gi].robid == commit1_robid))));
      assign flushed[gi] = flush_valid & entries_reg[gi].valid & ~committed_c[gi]
                         & rob_younger(entries_reg[gi].robid, flush_robid);
    end
  endgenerate

  // Flushed entries form the youngest suffix, so rewinding tail by their count
  // lands on the oldest flushed slot.
  always_comb begin
    flush_cnt = '0;
    for (int i = 0; i < SQ_NUM; i++)
      flush_cnt = flush_cnt + (SQ_WIDTH+1)'(flushed[i]);
  end

  always_comb begin
    entries_next = entries_reg;
    for (int i = 0; i < SQ_NUM; i++) begin
      entries_next[i].committed = committed_c[i];
      if (flushed[i]) begin
        entries_next[i].valid     = 1'b0;
        entries_next[i].committed = 1'b0;
      end
    end
    if (drain) begin
      entries_next[head_reg].valid     = 1'b0;
      entries_next[head_reg].committed = 1'b0;
    end
    if (alloc) begin
      entries_next[tail_reg].valid     = 1'b1;
      entries_next[tail_reg].committed = 1'b0;
      entries_next[tail_reg].addr      = st_addr[31:2];
      entries_next[tail_reg].data      = st_data << {st_addr[1:0], 3'b000};
      entries_next[tail_reg].mask      = size_mask(st_size, st_addr[1:0]);
      entries_next[tail_reg].robid     = st_robid;
    end
    head_next  = head_reg + SQ_WIDTH'(drain);
    tail_next  = tail_reg + SQ_WIDTH'(alloc) - SQ_WIDTH'(flush_cnt);
    count_next = count_reg + (SQ_WIDTH+1)'(alloc) - (SQ_WIDTH+1)'(drain) - flush_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_reg <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
    end else begin
      entries_reg <= entries_next;
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
    end
  end

  assign sq_full      = (count_reg >= FULL_LEVEL);
  assign sq_empty     = (count_reg == '0);
  assign dc_req_valid = entries_reg[head_reg].valid & entries_reg[head_reg].committed;
  assign dc_req_addr  = {entries_reg[head_reg].addr, 2'b00};
  assign dc_req_data  = entries_reg[head_reg].data;
  assign dc_req_mask  = entries_reg[head_reg].mask;

  sq_fwd_lookup #(
    .SQ_NUM   (SQ_NUM),
    .SQ_WIDTH (SQ_WIDTH)
  ) u_fwd (
    .entries   (entries_reg),
    .head      (head_reg),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_size   (ld_size),
    .ld_robid  (ld_robid),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_stall (fwd_stall)
  );

endmodule
